// File: rtl/m_lat_rf_2p.sv
`default_nettype none
// m_lat_rf_2p: DEPTH x WIDTH latch-array register file, one write port (IDLE/COMMIT) and one registered read port.
// Optional build macro: M_LAT_RF_WR_BYPASS_EN (read of the committing word returns new data).  Rev 1.0
module m_lat_rf_2p #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_vld
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_COMMIT = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [AW-1:0]               stage_addr_q;
    logic [WIDTH-1:0]            stage_data_q;
    logic [DEPTH-1:0]            valid_q;
    logic [WIDTH-1:0]            rd_data_q, rd_data_d;
    logic                        rd_vld_q;
    logic [DEPTH-1:0][WIDTH-1:0] word_q;
    logic                        stage_inrange, rd_inrange, wr_inrange;
    logic                        commit_en, rd_hit;
    logic [WIDTH-1:0]            rd_arr, wr_arr;

    assign stage_inrange = ({1'b0, stage_addr_q} < DEPTH_W);
    assign rd_inrange    = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_inrange    = ({1'b0, wr_addr} < DEPTH_W);
    assign commit_en     = (state_q == S_COMMIT) && stage_inrange;

    // Gate is low only while clk is low in COMMIT; all select terms come from
    // flops that settle during the high phase, so the gate cannot glitch.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic gate_n;
        assign gate_n = ~(commit_en && (stage_addr_q == AW'(w)) && !clk);
        for (genvar b = 0; b < WIDTH; b++) begin : g_bit
            logic cell_q;
            always_latch begin
                if (!gate_n) cell_q = stage_data_q[b];
            end
            assign word_q[w][b] = cell_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) state_d = S_COMMIT;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign rd_arr = (rd_inrange && valid_q[rd_addr]) ? word_q[rd_addr] : '0;
    assign wr_arr = (wr_inrange && valid_q[wr_addr]) ? word_q[wr_addr] : '0;
    assign rd_hit = commit_en && (rd_addr == stage_addr_q);

`ifdef M_LAT_RF_WR_BYPASS_EN
    assign rd_data_d = rd_hit ? stage_data_q : rd_arr;
`else
    // The latch is already overwritten by the end of COMMIT, so the old word
    // is snapshotted at accept time to keep pre-write read semantics.
    logic [WIDTH-1:0] snap_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
        end else if (wr_valid && wr_ready) begin
            snap_q <= wr_arr;
        end
    end
    assign rd_data_d = rd_hit ? snap_q : rd_arr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            stage_addr_q <= '0;
            stage_data_q <= '0;
            valid_q      <= '0;
            rd_data_q    <= '0;
            rd_vld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_vld_q <= rd_en;
            if (wr_valid && wr_ready) begin
                stage_addr_q <= wr_addr;
                stage_data_q <= wr_data;
            end
            if (commit_en) valid_q[stage_addr_q] <= 1'b1;
            if (rd_en) rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_vld  = rd_vld_q;

`ifdef M_LAT_RF_WR_BYPASS_EN
    logic unused_wr_arr;
    assign unused_wr_arr = ^wr_arr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_m_lat_rf_2p.sv
`default_nettype none
// tb_m_lat_rf_2p: scoreboard bench for m_lat_rf_2p (DEPTH=8 and DEPTH=6 instances).
module tb_m_lat_rf_2p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        wr_valid8 = 1'b0, wr_ready8, rd_en8 = 1'b0, rd_vld8;
    logic [2:0]  wr_addr8 = '0, rd_addr8 = '0;
    logic [31:0] wr_data8 = '0, rd_data8;
    logic        wr_valid6 = 1'b0, wr_ready6, rd_en6 = 1'b0, rd_vld6;
    logic [2:0]  wr_addr6 = '0, rd_addr6 = '0;
    logic [31:0] wr_data6 = '0, rd_data6;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q8[$];
    exp_t q6[$];

    m_lat_rf_2p #(.WIDTH(32), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid8), .wr_ready(wr_ready8), .wr_addr(wr_addr8), .wr_data(wr_data8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8), .rd_vld(rd_vld8)
    );

    m_lat_rf_2p #(.WIDTH(32), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid6), .wr_ready(wr_ready6), .wr_addr(wr_addr6), .wr_data(wr_data6),
        .rd_en(rd_en6), .rd_addr(rd_addr6), .rd_data(rd_data6), .rd_vld(rd_vld6)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input bit s6, input logic v, input logic [2:0] a, input logic [31:0] d);
        if (s6) begin
            wr_valid6 = v; wr_addr6 = a; wr_data6 = d;
        end else begin
            wr_valid8 = v; wr_addr8 = a; wr_data8 = d;
        end
    endtask

    task automatic push(input bit s6, input logic [31:0] e);
        exp_t x;
        x.data = e;
        x.due  = cyc + 1;
        if (s6) q6.push_back(x);
        else    q8.push_back(x);
    endtask

    task automatic rd(input bit s6, input logic [2:0] a, input logic [31:0] e);
        push(s6, e);
        if (s6) begin rd_en6 = 1'b1; rd_addr6 = a; end
        else    begin rd_en8 = 1'b1; rd_addr8 = a; end
        tick();
        rd_en6 = 1'b0;
        rd_en8 = 1'b0;
    endtask

    task automatic wr(input bit s6, input logic [2:0] a, input logic [31:0] d);
        set_wr(s6, 1'b1, a, d);
        chk("wr_ready_idle", s6 ? wr_ready6 : wr_ready8, 1);
        tick();
        set_wr(s6, 1'b0, a, d);
        chk("wr_ready_commit", s6 ? wr_ready6 : wr_ready8, 0);
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rd_vld8) begin
            if (q8.size() == 0) begin
                chk("rd8_unexpected_vld", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("rd8_data", rd_data8, e.data);
                chk("rd8_latency", cyc, e.due);
            end
        end
        if (rd_vld6) begin
            if (q6.size() == 0) begin
                chk("rd6_unexpected_vld", 1, 0);
            end else begin
                e = q6.pop_front();
                chk("rd6_data", rd_data6, e.data);
                chk("rd6_latency", cyc, e.due);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_byp;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_wr_ready", wr_ready8, 1);
        chk("reset_rd_vld", rd_vld8, 0);
        chk("reset_rd_data", rd_data8, 0);
        chk("reset_wr_ready6", wr_ready6, 1);

        rd(0, 3'd3, 32'h0000_0000);

        wr(0, 3'd5, 32'hDEAD_BEEF);
        rd(0, 3'd4, 32'h0);
        rd(0, 3'd6, 32'h0);
        rd(0, 3'd5, 32'hDEAD_BEEF);
        tick();
        chk("hold_rd_data", rd_data8, 32'hDEAD_BEEF);
        chk("idle_rd_vld", rd_vld8, 0);

        for (int j = 0; j < 8; j++) begin
            set_wr(0, 1'b1, 3'(j / 2), 32'h11 * (j / 2 + 1));
            chk("b2b_wr_ready", wr_ready8, (j % 2 == 0) ? 1 : 0);
            tick();
        end
        set_wr(0, 1'b0, 3'd0, 32'h0);
        for (int i = 0; i < 4; i++) rd(0, 3'(i), 32'h11 * (i + 1));

        wr(0, 3'd2, 32'hA5A5_A5A5);
        set_wr(0, 1'b1, 3'd2, 32'h5A5A_5A5A);
        chk("wr2_ready_idle", wr_ready8, 1);
        tick();
        set_wr(0, 1'b0, 3'd2, 32'h0);
        chk("wr2_ready_commit", wr_ready8, 0);
`ifdef M_LAT_RF_WR_BYPASS_EN
        exp_byp = 32'h5A5A_5A5A;
`else
        exp_byp = 32'hA5A5_A5A5;
`endif
        rd(0, 3'd2, exp_byp);
        rd(0, 3'd2, 32'h5A5A_5A5A);

        set_wr(0, 1'b1, 3'd7, 32'h7777_7777);
        tick();
        set_wr(0, 1'b0, 3'd7, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_wr_ready", wr_ready8, 1);
        chk("post_rst_rd_data", rd_data8, 0);
        rd(0, 3'd7, 32'h0);
        rd(0, 3'd5, 32'h0);

        wr(1, 3'd6, 32'h0000_FFFF);
        for (int i = 0; i < 7; i++) rd(1, 3'(i), 32'h0);
        wr(1, 3'd5, 32'h0000_1234);
        rd(1, 3'd5, 32'h0000_1234);
        rd(1, 3'd6, 32'h0);
        rd(1, 3'd0, 32'h0);

        repeat (3) tick();
        chk("q8_drained", q8.size(), 0);
        chk("q6_drained", q6.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
